// File: rtl/tdc_hit_encoder.sv
// TDC hit encoder: timestamps the first rising edge of the 4-phase pin samples after each event-window start
// and writes one {coarse, fine} entry per window into the result RAM.
module tdc_hit_encoder #(
  parameter int unsigned COARSE_W = 8,
  parameter int unsigned ADDR_W   = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                  clk100,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  evt_start,
  input  logic [3:0]            phase_smp,
  output logic                  ts_we,
  output logic [ADDR_W-1:0]     ts_addr,
  output logic [COARSE_W+1:0]   ts_data,
  output logic                  ts_nohit,
  output logic                  missed_hit,
  output logic [CNT_W-1:0]      win_cnt
);

  localparam int unsigned TS_W = COARSE_W + 2;

  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_e;

  state_e              state_q, state_d;
  logic [COARSE_W-1:0] coarse_q, coarse_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic                prev_q, prev_d;
  logic                ts_we_q, ts_we_d;
  logic [ADDR_W-1:0]   ts_addr_q, ts_addr_d;
  logic [TS_W-1:0]     ts_data_q, ts_data_d;
  logic                ts_nohit_q, ts_nohit_d;
  logic                missed_hit_q, missed_hit_d;
  logic [CNT_W-1:0]    win_cnt_q, win_cnt_d;

  logic [3:0] edge_v;
  logic       hit;
  logic [1:0] fine;
  logic       wr;
  logic       wr_nohit;

  // Rising-edge detection across the four phases, bit0 compared against last cycle's latest phase
  always_comb begin
    edge_v[0]   = phase_smp[0] & ~prev_q;
    edge_v[3:1] = phase_smp[3:1] & ~phase_smp[2:0];
    hit         = |edge_v;
    fine        = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (edge_v[i]) fine = 2'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    coarse_d     = coarse_q;
    prev_d       = phase_smp[3];
    wr           = 1'b0;
    wr_nohit     = 1'b0;
    missed_hit_d = 1'b0;

    if (!ena) begin
      state_d = IDLE;
    end else if (evt_start) begin
      // A new start always wins; an open window is closed as no-hit first
      state_d  = ARMED;
      coarse_d = '0;
      if (state_q == ARMED) begin
        wr           = 1'b1;
        wr_nohit     = 1'b1;
        missed_hit_d = hit;
      end
    end else if (state_q == ARMED) begin
      if (hit) begin
        wr      = 1'b1;
        state_d = DONE;
      end else if (&coarse_q) begin
        wr       = 1'b1;
        wr_nohit = 1'b1;
        state_d  = DONE;
      end else begin
        coarse_d = coarse_q + COARSE_W'(1);
      end
    end

    ts_we_d    = wr;
    ts_nohit_d = wr & wr_nohit;
    ts_addr_d  = wr ? wr_ptr_q : ts_addr_q;
    ts_data_d  = ts_data_q;
    if (wr) ts_data_d = wr_nohit ? {TS_W{1'b1}} : {coarse_q, fine};
    wr_ptr_d   = wr_ptr_q + ADDR_W'(wr);
    win_cnt_d  = win_cnt_q + CNT_W'(wr);
  end

  always_ff @(posedge clk100) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      coarse_q     <= '0;
      wr_ptr_q     <= '0;
      prev_q       <= 1'b1;
      ts_we_q      <= 1'b0;
      ts_addr_q    <= '0;
      ts_data_q    <= '0;
      ts_nohit_q   <= 1'b0;
      missed_hit_q <= 1'b0;
      win_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      coarse_q     <= coarse_d;
      wr_ptr_q     <= wr_ptr_d;
      prev_q       <= prev_d;
      ts_we_q      <= ts_we_d;
      ts_addr_q    <= ts_addr_d;
      ts_data_q    <= ts_data_d;
      ts_nohit_q   <= ts_nohit_d;
      missed_hit_q <= missed_hit_d;
      win_cnt_q    <= win_cnt_d;
    end
  end

  assign ts_we      = ts_we_q;
  assign ts_addr    = ts_addr_q;
  assign ts_data    = ts_data_q;
  assign ts_nohit   = ts_nohit_q;
  assign missed_hit = missed_hit_q;
  assign win_cnt    = win_cnt_q;

endmodule

// File: tb/tb_tdc_hit_encoder.sv
// Bench for tdc_hit_encoder: directed scenarios plus random pin/event traffic against a
// serial-scan reference model of the pin waveform.
module tb_tdc_hit_encoder;

  logic       clk100 = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       evt_start = 1'b0;
  logic [3:0] phase_smp = 4'b0000;
  logic       ts_we;
  logic [1:0] ts_addr;
  logic [9:0] ts_data;
  logic       ts_nohit;
  logic       missed_hit;
  logic [15:0] win_cnt;

  tdc_hit_encoder dut (
    .clk100     (clk100),
    .rst_n      (rst_n),
    .ena        (ena),
    .evt_start  (evt_start),
    .phase_smp  (phase_smp),
    .ts_we      (ts_we),
    .ts_addr    (ts_addr),
    .ts_data    (ts_data),
    .ts_nohit   (ts_nohit),
    .missed_hit (missed_hit),
    .win_cnt    (win_cnt)
  );

  always #5 clk100 = ~clk100;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: walks the pin waveform one quarter-cycle at a time
  bit m_last   = 1'b1;
  bit m_active = 1'b0;
  int m_cyc    = 0;
  int m_ptr    = 0;
  int m_cnt    = 0;
  int e_we = 0, e_addr = 0, e_data = 0, e_nohit = 0, e_missed = 0;

  function automatic void m_write(input int data, input int nohit);
    e_we    = 1;
    e_addr  = m_ptr;
    e_data  = data;
    e_nohit = nohit;
    m_ptr   = (m_ptr + 1) % 4;
    m_cnt   = (m_cnt + 1) % 65536;
  endfunction

  function automatic void model(input bit r, input bit en, input bit ev, input logic [3:0] s);
    int pos;
    bit l;
    e_we = 0; e_nohit = 0; e_missed = 0;
    if (!r) begin
      m_last = 1'b1; m_active = 1'b0; m_cyc = 0; m_ptr = 0; m_cnt = 0;
      e_addr = 0; e_data = 0;
      return;
    end
    pos = -1;
    l = m_last;
    for (int k = 0; k < 4; k++) begin
      if (s[k] && !l && pos < 0) pos = k;
      l = s[k];
    end
    if (!en) begin
      m_active = 1'b0;
    end else if (ev) begin
      if (m_active) begin
        m_write(1023, 1);
        e_missed = (pos >= 0);
      end
      m_active = 1'b1;
      m_cyc = 0;
    end else if (m_active) begin
      if (pos >= 0) begin
        m_write(m_cyc * 4 + pos, 0);
        m_active = 1'b0;
      end else if (m_cyc == 255) begin
        m_write(1023, 1);
        m_active = 1'b0;
      end else begin
        m_cyc++;
      end
    end
    m_last = s[3];
  endfunction

  task automatic step(input bit r, input bit en, input bit ev, input logic [3:0] s);
    rst_n = r; ena = en; evt_start = ev; phase_smp = s;
    model(r, en, ev, s);
    @(posedge clk100);
    #1;
    chk("ts_we", 32'(ts_we), 32'(e_we));
    chk("ts_nohit", 32'(ts_nohit), 32'(e_nohit));
    chk("missed_hit", 32'(missed_hit), 32'(e_missed));
    chk("ts_addr", 32'(ts_addr), 32'(e_addr));
    chk("ts_data", 32'(ts_data), 32'(e_data));
    chk("win_cnt", 32'(win_cnt), 32'(m_cnt));
  endtask

  task automatic run(input logic [3:0] s, input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, s);
  endtask

  initial begin
    logic [3:0] smp;
    bit pin;

    // Reset state
    step(0, 0, 0, 4'b0000);
    step(0, 0, 0, 4'b0000);
    chk("rst_data", 32'(ts_data), 32'd0);
    chk("rst_cnt", 32'(win_cnt), 32'd0);

    // Basic hit at window cycle 3, fine 2
    step(1, 1, 1, 4'b0000);
    run(4'b0000, 3);
    step(1, 1, 0, 4'b1100);
    chk("basic_we", 32'(ts_we), 32'd1);
    chk("basic_data", 32'(ts_data), 32'd14);
    chk("basic_addr", 32'(ts_addr), 32'd0);
    chk("basic_cnt", 32'(win_cnt), 32'd1);
    run(4'b0000, 2);

    // Edge on the latest phase
    step(1, 1, 1, 4'b0000);
    run(4'b0000, 5);
    step(1, 1, 0, 4'b1000);
    chk("bit3_data", 32'(ts_data), 32'd23);
    step(1, 1, 0, 4'b1111);
    run(4'b0000, 2);

    // Edge on the earliest phase against a low previous sample
    step(1, 1, 1, 4'b0000);
    run(4'b0000, 7);
    step(1, 1, 0, 4'b1111);
    chk("bit0_data", 32'(ts_data), 32'd28);
    chk("bit0_nohit", 32'(ts_nohit), 32'd0);

    // Pin high throughout: timeout entry at coarse 255
    run(4'b1111, 3);
    step(1, 1, 1, 4'b1111);
    run(4'b1111, 256);
    chk("tmo_we", 32'(ts_we), 32'd1);
    chk("tmo_data", 32'(ts_data), 32'h3FF);
    chk("tmo_nohit", 32'(ts_nohit), 32'd1);

    // Five windows wrap the 4-slot RAM
    step(0, 1, 0, 4'b0000);
    for (int h = 1; h <= 5; h++) begin
      step(1, 1, 1, 4'b0000);
      run(4'b0000, h);
      step(1, 1, 0, 4'b1111);
      chk("wrap_addr", 32'(ts_addr), 32'((h - 1) % 4));
      chk("wrap_data", 32'(ts_data), 32'(h * 4));
    end
    chk("wrap_cnt", 32'(win_cnt), 32'd5);

    // Collision: edge coincides with a restart
    step(1, 1, 0, 4'b0000);
    step(1, 1, 1, 4'b0000);
    run(4'b0000, 2);
    step(1, 1, 1, 4'b1111);
    chk("col_missed", 32'(missed_hit), 32'd1);
    chk("col_nohit", 32'(ts_nohit), 32'd1);
    chk("col_data", 32'(ts_data), 32'h3FF);
    step(1, 1, 0, 4'b0000);
    chk("col_missed_end", 32'(missed_hit), 32'd0);
    step(1, 1, 0, 4'b0000);
    step(1, 1, 0, 4'b0011);
    chk("col_new_data", 32'(ts_data), 32'd8);

    // Reset mid-window
    step(1, 1, 1, 4'b0000);
    run(4'b0000, 2);
    step(0, 1, 0, 4'b0000);
    chk("midrst_we", 32'(ts_we), 32'd0);
    chk("midrst_data", 32'(ts_data), 32'd0);
    step(1, 1, 1, 4'b0000);
    step(1, 1, 0, 4'b1111);
    chk("midrst_addr", 32'(ts_addr), 32'd0);
    chk("midrst_data2", 32'(ts_data), 32'd0);

    // Enable dropped while armed; starts ignored while disabled
    step(1, 1, 1, 4'b0000);
    step(1, 1, 0, 4'b0000);
    step(1, 0, 0, 4'b0000);
    step(1, 0, 1, 4'b0000);
    step(1, 1, 0, 4'b1111);
    chk("ena_we", 32'(ts_we), 32'd0);
    chk("ena_cnt", 32'(win_cnt), 32'd1);

    // Random traffic
    pin = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 11) == 0) pin = ~pin;
        smp[k] = pin;
      end
      step(($urandom_range(0, 499) != 0), ($urandom_range(0, 59) != 0),
           ($urandom_range(0, 29) == 0), smp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
